// File: rtl/bin2bcd_pkg.sv
// ============================================================================
// Module   : bin2bcd_pkg
// Brief    : Shared types and sizing constants for the binary-to-BCD converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGITS  = 5;
  localparam int DISP_DIGITS = 4;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int DISP_W      = 4 * DISP_DIGITS;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : One double-dabble digit correction: add 3 when the digit is >= 5.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Inputs are 0..9, so the result tops out at 12 and never leaves the nibble.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Iterative double-dabble converter, one bit per clock, 4-digit out.
//            Build macro BIN2BCD_SAT_EN: saturate bcd to 9999 on overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin,
  output logic              ready,
  output logic              done,
  output logic [DISP_W-1:0] bcd,
  output logic              ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SCR_W = BCD_W + WIDTH;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCR_W-1:0]   r_scr;
  logic [BCD_W-1:0]   w_adj;
  logic               w_last;
  logic               w_ovf;
  logic [DISP_W-1:0]  w_bcd;

  generate
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (r_scr[WIDTH + 4*g +: 4]),
        .dout (w_adj[4*g +: 4])
      );
    end
  endgenerate

  assign w_last = (r_cnt == CNT_W'(WIDTH));
  assign w_ovf  = |r_scr[SCR_W-1 -: 4];

`ifdef BIN2BCD_SAT_EN
  assign w_bcd = w_ovf ? {DISP_DIGITS{4'h9}} : r_scr[WIDTH +: DISP_W];
`else
  assign w_bcd = r_scr[WIDTH +: DISP_W];
`endif

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_scr   <= '0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_scr <= {{BCD_W{1'b0}}, bin};
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          // Shifting finishes on the WIDTH-th edge; the following edge publishes.
          if (!w_last) begin
            r_scr <= {w_adj, r_scr[WIDTH-1:0]} << 1;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            bcd <= w_bcd;
            ovf <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
